// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor.
// Direct-mapped BTB of 2-bit saturating counters, a combinational IF lookup,
// combinational ID-stage mispredict/redirect, and saturating statistics.
//
// Handshake: IDValid is a single-cycle qualifier on IDPC/IDCompare/IDTarget/
// IDPredTaken/IDPredTarget. Every cycle it is high is one resolve, and that
// resolve is consumed at the next rising edge. There is no ready/backpressure
// because the block always accepts a resolve.
module branch_predictor #(
  parameter int IDX_BITS = 6
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] IFPC,
  output logic        PredTaken,
  output logic [31:0] PredTarget,
  input  logic        IDValid,
  input  logic [31:0] IDPC,
  input  logic        IDCompare,
  input  logic [31:0] IDTarget,
  input  logic        IDPredTaken,
  input  logic [31:0] IDPredTarget,
  output logic        Mispredict,
  output logic [31:0] RedirectPC,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T  = 2'b10;
  localparam logic [1:0] CTR_MAX     = 2'b11;
  localparam logic [1:0] CTR_MIN     = 2'b00;

  // Flop-based table so the whole thing clears in one reset cycle.
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [31:0] branch_cnt_q;
  logic [31:0] mispredict_cnt_q;

  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] id_idx;
  logic [TAG_W-1:0]    if_tag;
  logic [TAG_W-1:0]    id_tag;
  logic [31:0]         if_pc_plus4;
  logic [31:0]         id_pc_plus4;
  logic                if_hit;
  logic                id_hit;
  logic                mispredict_raw;

  // PC[1:0] never participates: instructions are word aligned.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{IFPC[1:0], IDPC[1:0]};

  assign if_idx      = IFPC[IDX_BITS+1:2];
  assign if_tag      = IFPC[31:IDX_BITS+2];
  assign id_idx      = IDPC[IDX_BITS+1:2];
  assign id_tag      = IDPC[31:IDX_BITS+2];
  assign if_pc_plus4 = IFPC + 32'd4;
  assign id_pc_plus4 = IDPC + 32'd4;

  assign BranchCount     = branch_cnt_q;
  assign MispredictCount = mispredict_cnt_q;

  // IF lookup from the registered table; gated off while reset is held so
  // an uninitialised table never produces a prediction.
  always_comb begin
    if_hit     = Rst && valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    PredTaken  = if_hit && ctr_q[if_idx][1];
    PredTarget = PredTaken ? target_q[if_idx] : if_pc_plus4;
  end

  // ID resolve: compare carried prediction against the actual outcome.
  always_comb begin
    mispredict_raw = IDValid &&
                     ((IDCompare != IDPredTaken) ||
                      (IDCompare && (IDPredTarget != IDTarget)));
    Mispredict     = Rst && mispredict_raw;
    RedirectPC     = (Rst && IDCompare) ? IDTarget : id_pc_plus4;
    id_hit         = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
  end

  // Table update and statistics; reset wins over any same-cycle resolve.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WEAK_NT;
      end
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (IDValid) begin
      if (id_hit) begin
        if (IDCompare) begin
          if (ctr_q[id_idx] != CTR_MAX) ctr_q[id_idx] <= ctr_q[id_idx] + 2'd1;
          target_q[id_idx] <= IDTarget;
        end else if (ctr_q[id_idx] != CTR_MIN) begin
          ctr_q[id_idx] <= ctr_q[id_idx] - 2'd1;
        end
      end else if (IDCompare) begin
        // Taken miss allocates (or replaces an aliasing entry) as weak-taken.
        valid_q[id_idx]  <= 1'b1;
        tag_q[id_idx]    <= id_tag;
        target_q[id_idx] <= IDTarget;
        ctr_q[id_idx]    <= CTR_WEAK_T;
      end
      if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict_raw && (mispredict_cnt_q != '1))
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// a randomized back-to-back resolve stream checked against a reference model.
module tb_branch_predictor;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] IFPC;
  logic        PredTaken;
  logic [31:0] PredTarget;
  logic        IDValid;
  logic [31:0] IDPC;
  logic        IDCompare;
  logic [31:0] IDTarget;
  logic        IDPredTaken;
  logic [31:0] IDPredTarget;
  logic        Mispredict;
  logic [31:0] RedirectPC;
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;

  logic [31:0] exp_q[$];
  logic [31:0] e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_bc = 0;
  logic [31:0] exp_mc = 0;

  // Reference model table (64 entries, tag = PC[31:8]).
  logic        m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  logic [1:0]  m_ctr   [64];

  branch_predictor #(.IDX_BITS(6)) dut (
    .Clk(Clk), .Rst(Rst), .IFPC(IFPC), .PredTaken(PredTaken),
    .PredTarget(PredTarget), .IDValid(IDValid), .IDPC(IDPC),
    .IDCompare(IDCompare), .IDTarget(IDTarget), .IDPredTaken(IDPredTaken),
    .IDPredTarget(IDPredTarget), .Mispredict(Mispredict),
    .RedirectPC(RedirectPC), .BranchCount(BranchCount),
    .MispredictCount(MispredictCount)
  );

  // Clock and watchdog.
  always #5 Clk = ~Clk;
  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    IDValid = 1'b0; IDPC = 32'h0; IDCompare = 1'b0;
    IDTarget = 32'h0; IDPredTaken = 1'b0; IDPredTarget = 32'h0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic cmp,
                         input logic [31:0] tgt, input logic pt,
                         input logic [31:0] ptgt);
    IDValid = 1'b1; IDPC = pc; IDCompare = cmp;
    IDTarget = tgt; IDPredTaken = pt; IDPredTarget = ptgt;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Rst = 1'b0; IFPC = 32'h0040_0010;
    resolve(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    tick();
    tick();
    exp_q.push_back(32'd0); exp_q.push_back(32'h0040_0014);
    #1;
    e = exp_q.pop_front(); n_vec++; if ({31'b0, Mispredict} !== e) begin n_err++; $display("FAIL rst_hold_mispredict act=%0h exp=%0h", Mispredict, e); end
    e = exp_q.pop_front(); n_vec++; if (RedirectPC !== e) begin n_err++; $display("FAIL rst_hold_redirect act=%0h exp=%0h", RedirectPC, e); end
    Rst = 1'b1; idle();
    exp_q.push_back(32'd0); exp_q.push_back(32'h0040_0014);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); n_vec++; if ({31'b0, PredTaken} !== e) begin n_err++; $display("FAIL rst_pred_taken act=%0h exp=%0h", PredTaken, e); end
    e = exp_q.pop_front(); n_vec++; if (PredTarget !== e) begin n_err++; $display("FAIL rst_pred_target act=%0h exp=%0h", PredTarget, e); end
    e = exp_q.pop_front(); n_vec++; if (BranchCount !== e) begin n_err++; $display("FAIL rst_branch_count act=%0h exp=%0h", BranchCount, e); end
    e = exp_q.pop_front(); n_vec++; if (MispredictCount !== e) begin n_err++; $display("FAIL rst_mispredict_count act=%0h exp=%0h", MispredictCount, e); end
  endtask

  task automatic test_cold_taken();
    tick();
    IFPC = 32'h0040_0010;
    resolve(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    exp_q.push_back(32'd1); exp_q.push_back(32'h0040_0100); exp_q.push_back(32'd0);
    exp_bc++; exp_mc++;
    #1;
    e = exp_q.pop_front(); n_vec++; if ({31'b0, Mispredict} !== e) begin n_err++; $display("FAIL cold_mispredict act=%0h exp=%0h", Mispredict, e); end
    e = exp_q.pop_front(); n_vec++; if (RedirectPC !== e) begin n_err++; $display("FAIL cold_redirect act=%0h exp=%0h", RedirectPC, e); end
    e = exp_q.pop_front(); n_vec++; if ({31'b0, PredTaken} !== e) begin n_err++; $display("FAIL cold_same_cycle_pred act=%0h exp=%0h", PredTaken, e); end
    tick();
    idle();
    exp_q.push_back(32'd1); exp_q.push_back(32'h0040_0100);
    exp_q.push_back(exp_bc); exp_q.push_back(exp_mc);
    #1;
    e = exp_q.pop_front(); n_vec++; if ({31'b0, PredTaken} !== e) begin n_err++; $display("FAIL cold_next_pred act=%0h exp=%0h", PredTaken, e); end
    e = exp_q.pop_front(); n_vec++; if (PredTarget !== e) begin n_err++; $display("FAIL cold_next_target act=%0h exp=%0h", PredTarget, e); end
    e = exp_q.pop_front(); n_vec++; if (BranchCount !== e) begin n_err++; $display("FAIL cold_branch_count act=%0h exp=%0h", BranchCount, e); end
    e = exp_q.pop_front(); n_vec++; if (MispredictCount !== e) begin n_err++; $display("FAIL cold_mispredict_count act=%0h exp=%0h", MispredictCount, e); end
  endtask

  task automatic test_saturation();
    tick();
    IFPC = 32'h0040_0010;
    for (int i = 0; i < 3; i++) begin
      resolve(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100);
      exp_q.push_back(32'd0); exp_bc++;
      #1;
      e = exp_q.pop_front(); n_vec++; if ({31'b0, Mispredict} !== e) begin n_err++; $display("FAIL sat_taken_mispredict[%0d] act=%0h exp=%0h", i, Mispredict, e); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      resolve(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
      exp_q.push_back(32'd1); exp_q.push_back(32'h0040_0014);
      exp_bc++; exp_mc++;
      #1;
      e = exp_q.pop_front(); n_vec++; if ({31'b0, Mispredict} !== e) begin n_err++; $display("FAIL sat_nt_mispredict[%0d] act=%0h exp=%0h", i, Mispredict, e); end
      e = exp_q.pop_front(); n_vec++; if (RedirectPC !== e) begin n_err++; $display("FAIL sat_nt_redirect[%0d] act=%0h exp=%0h", i, RedirectPC, e); end
      tick();
      idle();
      // After one not-taken ctr is 10 (still taken); after two it is 01.
      exp_q.push_back((i == 0) ? 32'd1 : 32'd0);
      exp_q.push_back((i == 0) ? 32'h0040_0100 : 32'h0040_0014);
      #1;
      e = exp_q.pop_front(); n_vec++; if ({31'b0, PredTaken} !== e) begin n_err++; $display("FAIL sat_hyst_pred[%0d] act=%0h exp=%0h", i, PredTaken, e); end
      e = exp_q.pop_front(); n_vec++; if (PredTarget !== e) begin n_err++; $display("FAIL sat_hyst_target[%0d] act=%0h exp=%0h", i, PredTarget, e); end
      tick();
    end
    exp_q.push_back(exp_bc); exp_q.push_back(exp_mc);
    e = exp_q.pop_front(); n_vec++; if (BranchCount !== e) begin n_err++; $display("FAIL sat_branch_count act=%0h exp=%0h", BranchCount, e); end
    e = exp_q.pop_front(); n_vec++; if (MispredictCount !== e) begin n_err++; $display("FAIL sat_mispredict_count act=%0h exp=%0h", MispredictCount, e); end
  endtask

  task automatic test_target_change();
    tick();
    IFPC = 32'h0040_0010;
    // ctr is 01: retrain to weak-taken with target 0x00400100.
    resolve(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    exp_bc++; exp_mc++;
    tick();
    resolve(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0100);
    exp_q.push_back(32'd1); exp_q.push_back(32'h0040_0100);
    exp_q.push_back(32'd1); exp_q.push_back(32'h0040_0200);
    exp_bc++; exp_mc++;
    #1;
    e = exp_q.pop_front(); n_vec++; if ({31'b0, PredTaken} !== e) begin n_err++; $display("FAIL tgt_old_pred act=%0h exp=%0h", PredTaken, e); end
    e = exp_q.pop_front(); n_vec++; if (PredTarget !== e) begin n_err++; $display("FAIL tgt_old_target act=%0h exp=%0h", PredTarget, e); end
    e = exp_q.pop_front(); n_vec++; if ({31'b0, Mispredict} !== e) begin n_err++; $display("FAIL tgt_mispredict act=%0h exp=%0h", Mispredict, e); end
    e = exp_q.pop_front(); n_vec++; if (RedirectPC !== e) begin n_err++; $display("FAIL tgt_redirect act=%0h exp=%0h", RedirectPC, e); end
    tick();
    idle();
    exp_q.push_back(32'd1); exp_q.push_back(32'h0040_0200); exp_q.push_back(exp_mc);
    #1;
    e = exp_q.pop_front(); n_vec++; if ({31'b0, PredTaken} !== e) begin n_err++; $display("FAIL tgt_new_pred act=%0h exp=%0h", PredTaken, e); end
    e = exp_q.pop_front(); n_vec++; if (PredTarget !== e) begin n_err++; $display("FAIL tgt_new_target act=%0h exp=%0h", PredTarget, e); end
    e = exp_q.pop_front(); n_vec++; if (MispredictCount !== e) begin n_err++; $display("FAIL tgt_mispredict_count act=%0h exp=%0h", MispredictCount, e); end
  endtask

  task automatic test_alias();
    tick();
    // 0x00400110 shares index 4 with the resident 0x00400010 entry.
    resolve(32'h0040_0110, 1'b0, 32'h0040_0300, 1'b0, 32'h0040_0114);
    exp_q.push_back(32'd0); exp_bc++;
    #1;
    e = exp_q.pop_front(); n_vec++; if ({31'b0, Mispredict} !== e) begin n_err++; $display("FAIL alias_nt_mispredict act=%0h exp=%0h", Mispredict, e); end
    tick();
    idle();
    IFPC = 32'h0040_0010;
    exp_q.push_back(32'd1); exp_q.push_back(32'h0040_0200);
    #1;
    e = exp_q.pop_front(); n_vec++; if ({31'b0, PredTaken} !== e) begin n_err++; $display("FAIL alias_keep_pred act=%0h exp=%0h", PredTaken, e); end
    e = exp_q.pop_front(); n_vec++; if (PredTarget !== e) begin n_err++; $display("FAIL alias_keep_target act=%0h exp=%0h", PredTarget, e); end
    IFPC = 32'h0040_0110;
    exp_q.push_back(32'd0); exp_q.push_back(32'h0040_0114);
    #1;
    e = exp_q.pop_front(); n_vec++; if ({31'b0, PredTaken} !== e) begin n_err++; $display("FAIL alias_other_pred act=%0h exp=%0h", PredTaken, e); end
    e = exp_q.pop_front(); n_vec++; if (PredTarget !== e) begin n_err++; $display("FAIL alias_other_target act=%0h exp=%0h", PredTarget, e); end
    tick();
    // Taken alias replaces the entry; same-cycle lookup still sees the old one.
    IFPC = 32'h0040_0010;
    resolve(32'h0040_0110, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0114);
    exp_q.push_back(32'd1); exp_q.push_back(32'h0040_0200); exp_q.push_back(32'd1);
    exp_bc++; exp_mc++;
    #1;
    e = exp_q.pop_front(); n_vec++; if ({31'b0, PredTaken} !== e) begin n_err++; $display("FAIL alias_rw_pred act=%0h exp=%0h", PredTaken, e); end
    e = exp_q.pop_front(); n_vec++; if (PredTarget !== e) begin n_err++; $display("FAIL alias_rw_target act=%0h exp=%0h", PredTarget, e); end
    e = exp_q.pop_front(); n_vec++; if ({31'b0, Mispredict} !== e) begin n_err++; $display("FAIL alias_rw_mispredict act=%0h exp=%0h", Mispredict, e); end
    tick();
    idle();
    exp_q.push_back(32'd0); exp_q.push_back(32'h0040_0014);
    #1;
    e = exp_q.pop_front(); n_vec++; if ({31'b0, PredTaken} !== e) begin n_err++; $display("FAIL alias_evicted_pred act=%0h exp=%0h", PredTaken, e); end
    e = exp_q.pop_front(); n_vec++; if (PredTarget !== e) begin n_err++; $display("FAIL alias_evicted_target act=%0h exp=%0h", PredTarget, e); end
    IFPC = 32'h0040_0110;
    exp_q.push_back(32'd1); exp_q.push_back(32'h0040_0300);
    #1;
    e = exp_q.pop_front(); n_vec++; if ({31'b0, PredTaken} !== e) begin n_err++; $display("FAIL alias_new_pred act=%0h exp=%0h", PredTaken, e); end
    e = exp_q.pop_front(); n_vec++; if (PredTarget !== e) begin n_err++; $display("FAIL alias_new_target act=%0h exp=%0h", PredTarget, e); end
  endtask

  task automatic test_pc_wrap();
    tick();
    IFPC = 32'hFFFF_FFFC;
    exp_q.push_back(32'd0); exp_q.push_back(32'h0000_0000);
    #1;
    e = exp_q.pop_front(); n_vec++; if ({31'b0, PredTaken} !== e) begin n_err++; $display("FAIL wrap_pred act=%0h exp=%0h", PredTaken, e); end
    e = exp_q.pop_front(); n_vec++; if (PredTarget !== e) begin n_err++; $display("FAIL wrap_target act=%0h exp=%0h", PredTarget, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] pcs [3];
    pcs[0] = 32'h0040_0010; pcs[1] = 32'h0040_0110; pcs[2] = 32'h0040_0040;
    tick();
    Rst = 1'b0;
    IFPC = 32'h0040_0110;
    resolve(32'h0040_0040, 1'b1, 32'h0040_0500, 1'b0, 32'h0040_0044);
    exp_q.push_back(32'd0); exp_q.push_back(32'h0040_0044);
    exp_q.push_back(32'd0); exp_q.push_back(32'h0040_0114);
    #1;
    e = exp_q.pop_front(); n_vec++; if ({31'b0, Mispredict} !== e) begin n_err++; $display("FAIL mid_mispredict act=%0h exp=%0h", Mispredict, e); end
    e = exp_q.pop_front(); n_vec++; if (RedirectPC !== e) begin n_err++; $display("FAIL mid_redirect act=%0h exp=%0h", RedirectPC, e); end
    e = exp_q.pop_front(); n_vec++; if ({31'b0, PredTaken} !== e) begin n_err++; $display("FAIL mid_pred act=%0h exp=%0h", PredTaken, e); end
    e = exp_q.pop_front(); n_vec++; if (PredTarget !== e) begin n_err++; $display("FAIL mid_target act=%0h exp=%0h", PredTarget, e); end
    tick();
    Rst = 1'b1; idle();
    exp_bc = 0; exp_mc = 0;
    exp_q.push_back(exp_bc); exp_q.push_back(exp_mc);
    #1;
    e = exp_q.pop_front(); n_vec++; if (BranchCount !== e) begin n_err++; $display("FAIL mid_branch_count act=%0h exp=%0h", BranchCount, e); end
    e = exp_q.pop_front(); n_vec++; if (MispredictCount !== e) begin n_err++; $display("FAIL mid_mispredict_count act=%0h exp=%0h", MispredictCount, e); end
    for (int i = 0; i < 3; i++) begin
      IFPC = pcs[i];
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); n_vec++; if ({31'b0, PredTaken} !== e) begin n_err++; $display("FAIL mid_invalid_pred[%0h] act=%0h exp=%0h", pcs[i], PredTaken, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [5];
    logic [31:0] tgts [4];
    logic [31:0] pc, tgt, ptgt, ifpc, eptgt;
    logic        v, cmp, pt, ept, emis, hit;
    logic [5:0]  ix;
    pcs[0] = 32'h0040_0010; pcs[1] = 32'h0040_0110; pcs[2] = 32'h0040_0020;
    pcs[3] = 32'h0040_0824; pcs[4] = 32'h1000_0010;
    tgts[0] = 32'h0040_0100; tgts[1] = 32'h0040_0200;
    tgts[2] = 32'h0040_0F00; tgts[3] = 32'h0000_1000;
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 2'b01;
    end
    tick();
    for (int c = 0; c < 60; c++) begin
      v    = ($urandom_range(0, 3) != 0);
      pc   = pcs[$urandom_range(0, 4)];
      cmp  = $urandom_range(0, 1) == 1;
      tgt  = tgts[$urandom_range(0, 3)];
      ifpc = pcs[$urandom_range(0, 4)];
      // Expected IF prediction from the model (pre-update contents).
      ix    = ifpc[7:2];
      hit   = m_valid[ix] && (m_tag[ix] == ifpc[31:8]);
      ept   = hit && m_ctr[ix][1];
      eptgt = ept ? m_tgt[ix] : ifpc + 32'd4;
      // Carried prediction for the ID branch, occasionally corrupted target.
      ix   = pc[7:2];
      hit  = m_valid[ix] && (m_tag[ix] == pc[31:8]);
      pt   = hit && m_ctr[ix][1];
      ptgt = pt ? m_tgt[ix] : pc + 32'd4;
      if ($urandom_range(0, 3) == 0) ptgt = tgts[$urandom_range(0, 3)];
      emis = v && ((cmp != pt) || (cmp && (ptgt != tgt)));
      IFPC = ifpc;
      if (v) resolve(pc, cmp, tgt, pt, ptgt);
      else begin idle(); IDPC = pc; IDCompare = cmp; IDTarget = tgt; end
      exp_q.push_back({31'b0, ept}); exp_q.push_back(eptgt);
      exp_q.push_back({31'b0, emis}); exp_q.push_back(cmp ? tgt : pc + 32'd4);
      #1;
      e = exp_q.pop_front(); n_vec++; if ({31'b0, PredTaken} !== e) begin n_err++; $display("FAIL b2b_pred[%0d] act=%0h exp=%0h", c, PredTaken, e); end
      e = exp_q.pop_front(); n_vec++; if (PredTarget !== e) begin n_err++; $display("FAIL b2b_target[%0d] act=%0h exp=%0h", c, PredTarget, e); end
      e = exp_q.pop_front(); n_vec++; if ({31'b0, Mispredict} !== e) begin n_err++; $display("FAIL b2b_mispredict[%0d] act=%0h exp=%0h", c, Mispredict, e); end
      e = exp_q.pop_front(); n_vec++; if (RedirectPC !== e) begin n_err++; $display("FAIL b2b_redirect[%0d] act=%0h exp=%0h", c, RedirectPC, e); end
      // Model update, applied at this edge.
      if (v) begin
        if (hit) begin
          if (cmp) begin
            if (m_ctr[ix] != 2'b11) m_ctr[ix] = m_ctr[ix] + 2'd1;
            m_tgt[ix] = tgt;
          end else if (m_ctr[ix] != 2'b00) m_ctr[ix] = m_ctr[ix] - 2'd1;
        end else if (cmp) begin
          m_valid[ix] = 1'b1; m_tag[ix] = pc[31:8]; m_tgt[ix] = tgt; m_ctr[ix] = 2'b10;
        end
        exp_bc++;
        if (emis) exp_mc++;
      end
      tick();
    end
    idle();
    exp_q.push_back(exp_bc); exp_q.push_back(exp_mc);
    #1;
    e = exp_q.pop_front(); n_vec++; if (BranchCount !== e) begin n_err++; $display("FAIL b2b_branch_count act=%0h exp=%0h", BranchCount, e); end
    e = exp_q.pop_front(); n_vec++; if (MispredictCount !== e) begin n_err++; $display("FAIL b2b_mispredict_count act=%0h exp=%0h", MispredictCount, e); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle();
    test_reset();
    test_cold_taken();
    test_saturation();
    test_target_change();
    test_alias();
    test_pc_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
